int_ctrl: RTL
=============

# int_ctrl

Interrupt controller that produces the single-cycle `int_in` request consumed by the execute stage and tracks that stage's `int_state` feedback. It collects rising edges from up to 16 external interrupt lines (audio/codec timers, I/O), holds them as pending, applies a software-written enable mask, and selects the highest-priority source. It then raises `int_in` together with a vector address for fetch, and waits for the execute stage to enter and leave the handler (via `ret`) before issuing the next request.

## Interface

- `NUM_SRC`, 4: number of interrupt sources, 1..16.
- `VEC_BASE`, 16'hFF00: handler vector for source 0.
- `VEC_STRIDE`, 4: address distance between consecutive source vectors.

- `clk` in 1: single clock; everything is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `irq` in NUM_SRC: level lines, synchronous to `clk`; a rising edge requests service.
- `inhibit` in 1: 1 means the pipeline cannot take an interrupt this cycle (stall or branch in flight).
- `int_state` in 1: the execute stage's interrupt-mode flag (its `int_state_out`, registered).
- `cfg_we` in 1: config write strobe.
- `cfg_addr` in 2: config register select.
- `cfg_wdata` in 16: config write data.
- `cfg_rdata` out 16: config read data, combinational from `cfg_addr`.
- `int_in` out 1: interrupt request to the execute stage; a one-cycle pulse.
- `int_id` out 4: index of the source being serviced.
- `int_vec` out 16: handler entry address for fetch.
- `busy` out 1: an interrupt is in flight (state is not IDLE).

## Operation

- **Edge detect**
  - `irq_q` is `irq` registered.
  - An edge is `irq & ~irq_q`.
  - An edge sets `pending[i]` at the next clock.
- **Config registers**
  - Addr 0, ENABLE[NUM_SRC-1:0]: read/write.
  - Addr 1, PENDING: read; a write clears each bit written as 1 (write-1-to-clear).
  - Addr 2, CAUSE: read-only; returns `int_id` zero-extended.
  - Addr 3, GEN: bit 0 is global enable; read/write.
  - Register bits above NUM_SRC (or above bit 0 for GEN) read as 0. Writes to addr 2 are ignored.
- **Eligibility**
  - `eligible = pending & ENABLE`.
  - Lowest index has highest priority.
- **State machine**
  - IDLE → FIRE when GEN[0] & |eligible & ~inhibit & ~int_state. On that edge:
    - `int_id` latches the winning index.
    - `int_vec` latches `VEC_BASE + id*VEC_STRIDE`, truncated to 16 bits.
    - The winner's pending bit is cleared.
  - FIRE: `int_in`=1 for exactly this cycle. `inhibit` is ignored. Always → ENTER.
  - ENTER: wait for `int_state`=1, then → SERVICE. Nested requests are blocked.
  - SERVICE: wait for `int_state`=0 (handler executed `ret`), then → IDLE.
- **Simultaneous events on the same bit**
  - Edge and winner-clear: set wins, so the source stays pending.
  - Edge and W1C write: set wins.
- Disabled sources still accumulate pending bits; enabling one later makes it eligible immediately.
- ENABLE or GEN writes during FIRE/ENTER/SERVICE do not abort the interrupt in flight.

## Timing

- **Reset values:** `int_in`=0, `int_id`=0, `int_vec`=VEC_BASE, `busy`=0, `cfg_rdata`=0. State is IDLE, and all registers plus `irq_q` are 0.
- Reset asserted in any state returns to IDLE immediately, and any `int_in` pulse is dropped.
- **Latency:**
  - `irq` rises in cycle n → pending set at end of n.
  - Eligibility is evaluated in n+1.
  - `int_in` is high in cycle n+2.
- `int_id`/`int_vec` are valid from the first FIRE cycle. They hold until the next FIRE.
- `int_in` never stays high for 2 consecutive cycles.
- At least 3 cycles separate two `int_in` pulses (FIRE, ENTER, SERVICE).
- Config writes take effect at the clock edge. A W1C in cycle n removes eligibility for the decision in n+1.
- `busy` is registered: it is 1 in FIRE, ENTER and SERVICE.

## Test plan

- **Basic request:** NUM_SRC=4, ENABLE=4'hF, GEN=1; pulse `irq[2]` in cycle 10.
  - `int_in`=1 only in cycle 12.
  - `int_id`=2, `int_vec`=16'hFF08, PENDING=0.
  - Raise `int_state` in 14 and drop it in 20 → `busy` falls after 20.
- **Priority:** edges on `irq[3]` and `irq[1]` in the same cycle.
  - First pulse has `int_id`=1.
  - After `int_state` goes 1 then 0, the second pulse has `int_id`=3 and `int_vec`=16'hFF0C.
- **Masking:** ENABLE=0, edge on `irq[0]`.
  - No `int_in`, and PENDING reads 1.
  - Writing ENABLE=1 → `int_in` two cycles later.
- **Inhibit:** hold `inhibit`=1 for 5 cycles while PENDING=4'b0001.
  - No pulse during those cycles.
  - `int_in` in the cycle after `inhibit` falls + 1.
  - With `int_state`=1 held, no pulse occurs.
- **Set-wins and W1C:**
  - A W1C of bit 0 in the same cycle as an `irq[0]` edge → PENDING bit 0 stays 1.
  - W1C alone → PENDING bit 0 reads 0 the next cycle.
- **Reset mid-flight:** assert `rst_n`=0 during ENTER.
  - `busy`=0 and `int_in`=0 with no clock needed.
  - `int_vec`=16'hFF00, and all registers read 0 after release.

Source files
------------

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-captured pending sources, enable mask, fixed priority,
// and a FIRE/ENTER/SERVICE handshake with the execute stage's interrupt-mode flag.
module int_ctrl #(
  parameter int          NUM_SRC    = 4,
  parameter logic [15:0] VEC_BASE   = 16'hFF00,
  parameter int          VEC_STRIDE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq,
  input  logic               inhibit,
  input  logic               int_state,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [15:0]        cfg_wdata,
  output logic [15:0]        cfg_rdata,
  output logic               int_in,
  output logic [3:0]         int_id,
  output logic [15:0]        int_vec,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, FIRE, ENTER, SERVICE} state_t;

  state_t             state;
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable;
  logic               gen;

  logic [NUM_SRC-1:0] edges;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] win_mask;
  logic [NUM_SRC-1:0] w1c_mask;
  logic [NUM_SRC-1:0] pending_nxt;
  logic [3:0]         win_id;
  logic               win_any;
  logic               take;
  logic               unused_wdata;

  function automatic logic [15:0] vec_addr(input logic [3:0] id);
    return 16'(32'(VEC_BASE) + 32'(id) * 32'(VEC_STRIDE));
  endfunction

  assign edges    = irq & ~irq_q;
  assign eligible = pending & enable;
  assign w1c_mask = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[NUM_SRC-1:0] : '0;
  assign take     = (state == IDLE) && gen && win_any && !inhibit && !int_state;
  // A new edge is OR-ed in last so it survives both the W1C and the winner clear.
  assign pending_nxt = (pending & ~w1c_mask & ~(take ? win_mask : '0)) | edges;
  assign unused_wdata = ^cfg_wdata;

  // Scan from the top so the lowest eligible index is the one left standing.
  always_comb begin
    win_any  = 1'b0;
    win_id   = '0;
    win_mask = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_any     = 1'b1;
        win_id      = 4'(i);
        win_mask    = '0;
        win_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    cfg_rdata = 16'h0000;
    case (cfg_addr)
      2'd0:    cfg_rdata = 16'(enable);
      2'd1:    cfg_rdata = 16'(pending);
      2'd2:    cfg_rdata = {12'h000, int_id};
      default: cfg_rdata = {15'h0000, gen};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q   <= '0;
      pending <= '0;
      enable  <= '0;
      gen     <= 1'b0;
    end else begin
      irq_q   <= irq;
      pending <= pending_nxt;
      if (cfg_we && cfg_addr == 2'd0) enable <= cfg_wdata[NUM_SRC-1:0];
      if (cfg_we && cfg_addr == 2'd3) gen    <= cfg_wdata[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      int_in  <= 1'b0;
      busy    <= 1'b0;
      int_id  <= '0;
      int_vec <= VEC_BASE;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            state   <= FIRE;
            int_in  <= 1'b1;
            busy    <= 1'b1;
            int_id  <= win_id;
            int_vec <= vec_addr(win_id);
          end
        end
        FIRE: begin
          state  <= ENTER;
          int_in <= 1'b0;
        end
        ENTER: begin
          if (int_state) state <= SERVICE;
        end
        default: begin
          if (!int_state) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
